trdb_capture_ctrl: RTL and testbench
====================================

Name: trdb_capture_ctrl

Overview:
Capture sequencer between the core's instruction-sample interface and the trace packet encoder.
- Decides which retired-instruction samples enter the trace: enable, start/stop address triggers, privilege filter.
- Buffers accepted samples in a 2-entry FIFO and presents them over a valid/ready handshake.
- Counts samples lost to backpressure.

Parameters:
DROP_CNT_W, 16, width of saturating dropped-sample counter
ADDR_W, 32, instruction address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  tracing enable (level)
use_trigger_i  in  1  1: gate tracing by start/stop address; 0: trace whenever enabled
start_addr_i  in  ADDR_W  start trigger address
stop_addr_i  in  ADDR_W  stop trigger address
priv_mask_i  in  8  bit p set = capture samples with priv_i==p
ivalid_i  in  1  instruction retired this cycle
iexception_i  in  1  exception flag
interrupt_i  in  1  interrupt flag
cause_i  in  5  trap cause
priv_i  in  3  privilege level
iaddr_i  in  ADDR_W  instruction address
instr_i  in  32  instruction word
compressed_i  in  1  compressed instruction
sample_valid_o  out  1  output sample valid
sample_ready_i  in  1  downstream ready
sample_o  out  trdb_sample_t  packed sample + lost flag
tracing_o  out  1  state==TRACING
dropped_cnt_o  out  DROP_CNT_W  saturating count of dropped samples

Behaviour:
- Reset: state=IDLE, FIFO empty, sample_valid_o=0, sample_o=0, tracing_o=0, dropped_cnt_o=0, lost flag=0.
- Config inputs (use_trigger_i, start/stop, priv_mask_i) are quasi-static; changes are legal only in IDLE.
- Eligible sample: ivalid_i=1 and (priv_mask_i[priv_i]=1 or iexception_i or interrupt_i). Traps always bypass the priv filter.
- IDLE:
  - enable_i=1 and use_trigger_i=0 -> TRACING.
  - enable_i=1 and use_trigger_i=1 -> ARMED.
  - No capture in IDLE.
- ARMED:
  - ivalid_i and iaddr_i==start_addr_i -> TRACING. The matching sample is captured if eligible.
  - enable_i=0 -> IDLE.
- TRACING:
  - Capture every eligible sample.
  - use_trigger_i=1 and ivalid_i and iaddr_i==stop_addr_i -> FLUSH. The stop sample is captured if eligible.
  - enable_i=0 -> FLUSH. The sample in that cycle is not captured.
- Start and stop match on the same instruction (start==stop): one sample captured, ARMED -> FLUSH directly.
- FLUSH:
  - No capture.
  - Once FIFO is empty: enable_i=1 and use_trigger_i=1 -> ARMED (re-arm); otherwise -> IDLE.
- FIFO: 2 entries, first-word-fall-through from a register.
  - Capture in cycle N -> sample_valid_o=1 in cycle N+1 at the earliest.
  - Pop on sample_valid_o & sample_ready_i.
  - Simultaneous push and pop when full is allowed (no drop).
  - sample_o must remain stable while valid=1 and ready=0.
- Drop: capture attempted while FIFO full and no pop that cycle.
  - Sample discarded.
  - dropped_cnt_o increments, saturating at all-ones.
  - Internal lost flag set.
  - The next sample pushed carries lost=1; the flag then clears.
  - A drop in the same cycle as a push is impossible (single input).
- dropped_cnt_o clears only on reset. A 0->1 transition of enable_i does not clear it.
- Reset mid-operation: immediate asynchronous return to reset values; FIFO contents discarded.
- Address compare is full-width equality; no masking, no range.

Decomposition:
- trdb_pkg holds:
  - trdb_sample_t packed struct: lost, iexception, interrupt, cause[4:0], priv[2:0], compressed, iaddr, instr.
  - trdb_capt_state_e enum: IDLE, ARMED, TRACING, FLUSH.
- Sub-module trdb_sample_fifo: 2-entry, parameterised on the trdb_sample_t type, with push/pop/full/empty.
- Controller FSM, filter and drop counter live in trdb_capture_ctrl.

Test Plan:
- Enable, use_trigger=0, priv_mask=8'hFF, ready=1, 5 retires at 0x100..0x110 step 4 -> 5 samples out, each 1 cycle after input, lost=0, dropped=0.
- use_trigger=1, start=0x200, stop=0x20C, retires 0x1F8..0x210 step 4 -> output exactly 0x200,0x204,0x208,0x20C; then FLUSH -> ARMED; tracing_o high only over those cycles.
- ready=0, TRACING, 4 consecutive retires -> first 2 buffered, dropped_cnt=2; ready=1 -> 2 samples out with lost=0. Next captured sample has lost=1, following one lost=0.
- priv_mask=8'h08, retire priv=0 (normal), priv=0 with iexception=1 cause=5, priv=3 -> only the exception and priv=3 samples appear.
- start=stop=0x300, retire 0x300 -> single sample, ARMED -> FLUSH -> ARMED. Deassert enable_i mid-TRACING with 2 samples queued -> both drain, then IDLE.
- rst_ni low asynchronously mid-TRACING with a full FIFO -> sample_valid_o=0 and dropped_cnt_o=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/trdb_pkg.sv
// Shared types for the trace capture path: the sample record handed to the
// packet encoder, the capture controller state encoding and a filter helper.
package trdb_pkg;

  // Address width carried inside the sample record. The capture controller's
  // ADDR_W parameter must match this value.
  localparam int unsigned TRDB_ADDR_W  = 32;
  localparam int unsigned TRDB_INSTR_W = 32;
  localparam int unsigned TRDB_CAUSE_W = 5;
  localparam int unsigned TRDB_PRIV_W  = 3;

  // Capture controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRACING = 2'd2,
    FLUSH   = 2'd3
  } trdb_capt_state_e;

  // One retired-instruction sample as seen by the encoder. The lost flag
  // marks the first sample after one or more samples were discarded.
  typedef struct packed {
    logic                    lost;
    logic                    iexception;
    logic                    interrupt;
    logic [TRDB_CAUSE_W-1:0] cause;
    logic [TRDB_PRIV_W-1:0]  priv;
    logic                    compressed;
    logic [TRDB_ADDR_W-1:0]  iaddr;
    logic [TRDB_INSTR_W-1:0] instr;
  } trdb_sample_t;

  // A retired sample passes the filter when its privilege level is selected
  // in the mask, or when it is a trap (traps are never filtered out).
  function automatic logic trdb_sample_eligible(
    input logic                   ivalid,
    input logic [7:0]             priv_mask,
    input logic [TRDB_PRIV_W-1:0] priv,
    input logic                   iexception,
    input logic                   interrupt
  );
    return ivalid & (priv_mask[priv] | iexception | interrupt);
  endfunction

endpackage

// File: rtl/trdb_sample_fifo.sv
// Two-entry first-word-fall-through FIFO. The head entry is read straight
// from its storage register, so the output holds still until it is popped.
// A push while full is accepted only if a pop happens in the same cycle.
module trdb_sample_fifo #(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push_ok;
  logic       pop_ok;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign pop_ok  = pop_i & ~empty_o;
  // When full, the write slot equals the slot being popped, so a
  // simultaneous push/pop simply replaces the departing entry.
  assign push_ok = push_i & (~full_o | pop_ok);

  // Per-entry storage registers.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    T entry_q;
    T entry_d;

    // Load the entry when it is the write target of an accepted push.
    always_comb begin
      entry_d = entry_q;
      if (push_ok && (wr_ptr_q == 1'(gi))) begin
        entry_d = data_i;
      end
    end

    // Entry register; cleared on reset so no stale contents survive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        entry_q <= '0;
      end else begin
        entry_q <= entry_d;
      end
    end
  end

  // Output zero when empty so nothing stale is ever presented.
  assign data_o = empty_o ? T'('0) : (rd_ptr_q ? g_entry[1].entry_q : g_entry[0].entry_q);

  // Pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/trdb_capture_ctrl.sv
// Capture sequencer between the core's retired-instruction sample port and
// the trace packet encoder. Decides which samples are traced (enable,
// start/stop address triggers, privilege filter), buffers them in a
// two-entry FIFO and counts samples discarded because the FIFO was full.
module trdb_capture_ctrl
  import trdb_pkg::*;
#(
  parameter int unsigned DROP_CNT_W = 16,
  // Must equal TRDB_ADDR_W, the address width inside the sample record.
  parameter int unsigned ADDR_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  use_trigger_i,
  input  logic [ADDR_W-1:0]     start_addr_i,
  input  logic [ADDR_W-1:0]     stop_addr_i,
  input  logic [7:0]            priv_mask_i,
  input  logic                  ivalid_i,
  input  logic                  iexception_i,
  input  logic                  interrupt_i,
  input  logic [4:0]            cause_i,
  input  logic [2:0]            priv_i,
  input  logic [ADDR_W-1:0]     iaddr_i,
  input  logic [31:0]           instr_i,
  input  logic                  compressed_i,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output trdb_sample_t          sample_o,
  output logic                  tracing_o,
  output logic [DROP_CNT_W-1:0] dropped_cnt_o
);

  trdb_capt_state_e      state_q, state_d;
  logic [DROP_CNT_W-1:0] dropped_cnt_q, dropped_cnt_d;
  logic                  lost_q, lost_d;

  logic         eligible;
  logic         start_hit;
  logic         stop_hit;
  logic         capture;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         fifo_push;
  logic         drop;
  trdb_sample_t push_sample;

  assign eligible  = trdb_sample_eligible(ivalid_i, priv_mask_i, priv_i,
                                          iexception_i, interrupt_i);
  assign start_hit = ivalid_i & (iaddr_i == start_addr_i);
  assign stop_hit  = use_trigger_i & ivalid_i & (iaddr_i == stop_addr_i);

  // Next-state and capture decision for the capture sequencer.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = use_trigger_i ? ARMED : TRACING;
        end
      end
      ARMED: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (start_hit) begin
          capture = eligible;
          // Start and stop on the same instruction: a one-sample window.
          state_d = stop_hit ? FLUSH : TRACING;
        end
      end
      TRACING: begin
        if (!enable_i) begin
          // Disabling stops capture in the same cycle.
          state_d = FLUSH;
        end else begin
          capture = eligible;
          if (stop_hit) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (fifo_empty) begin
          state_d = (enable_i && use_trigger_i) ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake: a capture is accepted unless the FIFO is full with no
  // departure this cycle, in which case the sample is discarded.
  assign fifo_pop  = sample_valid_o & sample_ready_i;
  assign fifo_push = capture & (~fifo_full | fifo_pop);
  assign drop      = capture & fifo_full & ~fifo_pop;

  // Assemble the record written into the FIFO.
  always_comb begin
    push_sample            = '0;
    push_sample.lost       = lost_q;
    push_sample.iexception = iexception_i;
    push_sample.interrupt  = interrupt_i;
    push_sample.cause      = cause_i;
    push_sample.priv       = priv_i;
    push_sample.compressed = compressed_i;
    push_sample.iaddr      = iaddr_i;
    push_sample.instr      = instr_i;
  end

  // Lost flag and saturating drop counter.
  always_comb begin
    lost_d        = lost_q;
    dropped_cnt_d = dropped_cnt_q;
    if (drop) begin
      lost_d = 1'b1;
      if (dropped_cnt_q != {DROP_CNT_W{1'b1}}) begin
        dropped_cnt_d = dropped_cnt_q + DROP_CNT_W'(1);
      end
    end else if (fifo_push) begin
      // The pushed sample carries the flag; it is consumed here.
      lost_d = 1'b0;
    end
  end

  // State, lost flag and drop counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      lost_q        <= 1'b0;
      dropped_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      lost_q        <= lost_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  trdb_sample_fifo #(
    .T (trdb_sample_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .data_i  (push_sample),
    .pop_i   (fifo_pop),
    .data_o  (sample_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sample_valid_o = ~fifo_empty;
  assign tracing_o      = (state_q == TRACING);
  assign dropped_cnt_o  = dropped_cnt_q;

endmodule

// File: tb/tb_trdb_capture_ctrl.sv
// Directed bench for trdb_capture_ctrl: free-running start, trigger window,
// backpressure drops, privilege filter, one-sample window, disable drain
// and asynchronous reset.
module tb_trdb_capture_ctrl;
  import trdb_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         use_trigger;
  logic [31:0]  start_addr;
  logic [31:0]  stop_addr;
  logic [7:0]   priv_mask;
  logic         ivalid;
  logic         iexception;
  logic         interrupt;
  logic [4:0]   cause;
  logic [2:0]   priv;
  logic [31:0]  iaddr;
  logic [31:0]  instr;
  logic         compressed;
  logic         sample_valid;
  logic         sample_ready;
  trdb_sample_t sample;
  logic         tracing;
  logic [15:0]  dropped_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trdb_capture_ctrl #(
    .DROP_CNT_W (16),
    .ADDR_W     (32)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .use_trigger_i  (use_trigger),
    .start_addr_i   (start_addr),
    .stop_addr_i    (stop_addr),
    .priv_mask_i    (priv_mask),
    .ivalid_i       (ivalid),
    .iexception_i   (iexception),
    .interrupt_i    (interrupt),
    .cause_i        (cause),
    .priv_i         (priv),
    .iaddr_i        (iaddr),
    .instr_i        (instr),
    .compressed_i   (compressed),
    .sample_valid_o (sample_valid),
    .sample_ready_i (sample_ready),
    .sample_o       (sample),
    .tracing_o      (tracing),
    .dropped_cnt_o  (dropped_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [2:0] p,
                       input logic exc, input logic intr, input logic [4:0] c);
    ivalid     = 1'b1;
    iaddr      = a;
    instr      = a ^ 32'hDEAD_0000;
    compressed = a[2];
    priv       = p;
    iexception = exc;
    interrupt  = intr;
    cause      = c;
  endtask

  task automatic idle_in();
    ivalid     = 1'b0;
    iexception = 1'b0;
    interrupt  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; enable = 1'b0; use_trigger = 1'b0;
    start_addr = '0; stop_addr = '0; priv_mask = 8'hFF;
    ivalid = 1'b0; iexception = 1'b0; interrupt = 1'b0; cause = '0;
    priv = '0; iaddr = '0; instr = '0; compressed = 1'b0; sample_ready = 1'b1;

    // Reset values
    #2;
    chk("rst_valid",   64'(sample_valid), 64'd0);
    chk("rst_sample",  64'(sample != '0), 64'd0);
    chk("rst_tracing", 64'(tracing), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt), 64'd0);
    #6 rst_n = 1'b1;

    // Free-running trace: each sample appears one cycle after retirement
    enable = 1'b1;
    tick();
    chk("t1_tracing", 64'(tracing), 64'd1);
    for (int i = 0; i < 5; i++) begin
      a = 32'h100 + 32'(4 * i);
      drive(a, 3'd0, 1'b0, 1'b0, 5'd0);
      tick();
      chk("t1_valid", 64'(sample_valid), 64'd1);
      chk("t1_addr",  64'(sample.iaddr), 64'(a));
      chk("t1_instr", 64'(sample.instr), 64'(a ^ 32'hDEAD_0000));
      chk("t1_cmp",   64'(sample.compressed), 64'(a[2]));
      chk("t1_lost",  64'(sample.lost), 64'd0);
    end
    idle_in();
    tick();
    chk("t1_drained", 64'(sample_valid), 64'd0);
    chk("t1_dropped", 64'(dropped_cnt), 64'd0);
    enable = 1'b0;
    tick();
    chk("t1_flush_trc", 64'(tracing), 64'd0);
    chk("t1_flush",     64'(dut.state_q), 64'(FLUSH));
    tick();
    chk("t1_idle", 64'(dut.state_q), 64'(IDLE));

    // Start/stop trigger window 0x200..0x20C
    use_trigger = 1'b1; start_addr = 32'h200; stop_addr = 32'h20C; enable = 1'b1;
    tick();
    chk("t2_armed", 64'(dut.state_q), 64'(ARMED));
    for (int i = 0; i < 7; i++) begin
      a = 32'h1F8 + 32'(4 * i);
      drive(a, 3'd0, 1'b0, 1'b0, 5'd0);
      tick();
      chk("t2_valid",   64'(sample_valid), 64'((i >= 2) && (i <= 5)));
      chk("t2_tracing", 64'(tracing),      64'((i >= 2) && (i <= 4)));
      if ((i >= 2) && (i <= 5)) chk("t2_addr", 64'(sample.iaddr), 64'(a));
    end
    idle_in();
    tick();
    chk("t2_rearm",  64'(dut.state_q), 64'(ARMED));
    chk("t2_valid0", 64'(sample_valid), 64'd0);

    // Backpressure: two buffered, two dropped, lost flag on next push
    enable = 1'b0;
    tick();
    chk("t3_idle", 64'(dut.state_q), 64'(IDLE));
    use_trigger = 1'b0; enable = 1'b1;
    tick();
    sample_ready = 1'b0;
    drive(32'h400, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t3_addr0", 64'(sample.iaddr), 64'h400);
    chk("t3_lost0", 64'(sample.lost), 64'd0);
    drive(32'h404, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t3_stable1", 64'(sample.iaddr), 64'h400);
    chk("t3_drop0",   64'(dropped_cnt), 64'd0);
    drive(32'h408, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t3_stable2", 64'(sample.iaddr), 64'h400);
    chk("t3_drop1",   64'(dropped_cnt), 64'd1);
    drive(32'h40C, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t3_stable3", 64'(sample.iaddr), 64'h400);
    chk("t3_drop2",   64'(dropped_cnt), 64'd2);
    idle_in(); sample_ready = 1'b1;
    tick();
    chk("t3_valid1", 64'(sample_valid), 64'd1);
    chk("t3_addr1",  64'(sample.iaddr), 64'h404);
    chk("t3_lost1",  64'(sample.lost), 64'd0);
    tick();
    chk("t3_empty", 64'(sample_valid), 64'd0);
    drive(32'h410, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t3_addr2", 64'(sample.iaddr), 64'h410);
    chk("t3_lost2", 64'(sample.lost), 64'd1);
    drive(32'h414, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t3_addr3", 64'(sample.iaddr), 64'h414);
    chk("t3_lost3", 64'(sample.lost), 64'd0);
    idle_in();
    tick();
    chk("t3_done", 64'(sample_valid), 64'd0);

    // Privilege filter, traps bypass it; re-enable keeps the drop count
    enable = 1'b0;
    tick(); tick();
    priv_mask = 8'h08; enable = 1'b1;
    tick();
    chk("t4_keepcnt", 64'(dropped_cnt), 64'd2);
    drive(32'h500, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t4_filtered", 64'(sample_valid), 64'd0);
    drive(32'h504, 3'd0, 1'b1, 1'b0, 5'd5); tick();
    chk("t4_exc_addr",  64'(sample.iaddr), 64'h504);
    chk("t4_exc_flag",  64'(sample.iexception), 64'd1);
    chk("t4_exc_cause", 64'(sample.cause), 64'd5);
    drive(32'h508, 3'd3, 1'b0, 1'b0, 5'd0); tick();
    chk("t4_p3_addr", 64'(sample.iaddr), 64'h508);
    chk("t4_p3_priv", 64'(sample.priv), 64'd3);
    chk("t4_p3_exc",  64'(sample.iexception), 64'd0);
    drive(32'h50C, 3'd1, 1'b0, 1'b1, 5'd3); tick();
    chk("t4_irq_addr", 64'(sample.iaddr), 64'h50C);
    chk("t4_irq_flag", 64'(sample.interrupt), 64'd1);
    idle_in();
    tick();
    chk("t4_done", 64'(sample_valid), 64'd0);

    // start == stop: one-sample window, then re-arm
    enable = 1'b0;
    tick(); tick();
    priv_mask = 8'hFF; use_trigger = 1'b1; start_addr = 32'h300; stop_addr = 32'h300;
    enable = 1'b1;
    tick();
    chk("t5_armed", 64'(dut.state_q), 64'(ARMED));
    drive(32'h300, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t5_valid", 64'(sample_valid), 64'd1);
    chk("t5_addr",  64'(sample.iaddr), 64'h300);
    chk("t5_flush", 64'(dut.state_q), 64'(FLUSH));
    chk("t5_trc",   64'(tracing), 64'd0);
    idle_in();
    tick();
    chk("t5_single", 64'(sample_valid), 64'd0);
    tick();
    chk("t5_rearm", 64'(dut.state_q), 64'(ARMED));

    // Disable with two samples queued: both drain, then IDLE
    enable = 1'b0;
    tick();
    use_trigger = 1'b0; enable = 1'b1;
    tick();
    sample_ready = 1'b0;
    drive(32'h600, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    drive(32'h604, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    enable = 1'b0;
    drive(32'h608, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    chk("t5_dis_flush", 64'(dut.state_q), 64'(FLUSH));
    chk("t5_dis_head",  64'(sample.iaddr), 64'h600);
    chk("t5_dis_nodrop", 64'(dropped_cnt), 64'd2);
    idle_in(); sample_ready = 1'b1;
    tick();
    chk("t5_drain2", 64'(sample.iaddr), 64'h604);
    tick();
    chk("t5_drained", 64'(sample_valid), 64'd0);
    chk("t5_still_flush", 64'(dut.state_q), 64'(FLUSH));
    tick();
    chk("t5_idle", 64'(dut.state_q), 64'(IDLE));

    // Asynchronous reset while TRACING with a full FIFO
    enable = 1'b1;
    tick();
    sample_ready = 1'b0;
    drive(32'h700, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    drive(32'h704, 3'd0, 1'b0, 1'b0, 5'd0); tick();
    idle_in();
    chk("t6_full_valid", 64'(sample_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",   64'(sample_valid), 64'd0);
    chk("t6_rst_dropped", 64'(dropped_cnt), 64'd0);
    chk("t6_rst_tracing", 64'(tracing), 64'd0);
    chk("t6_rst_sample",  64'(sample != '0), 64'd0);
    enable = 1'b0; sample_ready = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    chk("t6_idle",  64'(dut.state_q), 64'(IDLE));
    chk("t6_valid", 64'(sample_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
